weight_read_sequencer: RTL

WEIGHT_READ_SEQUENCER -- requirements
Module: weight_read_sequencer

---
 rtl/fnn_pkg.sv | 15 +
 rtl/weight_read_sequencer.sv | 92 +++++++++
 2 files changed

// File: rtl/fnn_pkg.sv
// Shared definitions for the fully-connected neuron datapath: the weight
// read sequencer state encoding and the default layer geometry.
package fnn_pkg;

    localparam int DEF_NUM_WEIGHT = 10;
    localparam int DEF_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/weight_read_sequencer.sv
// Pairs each incoming input sample with its weight from a 1-cycle-latency
// memory and streams {w, x} pairs to the MAC, one pass of numWeight per start.
module weight_read_sequencer
    import fnn_pkg::*;
#(
    parameter int numWeight    = DEF_NUM_WEIGHT,
    parameter int dataWidth    = DEF_DATA_WIDTH,
    parameter int addressWidth = $clog2(numWeight)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    x_valid,
    input  logic [dataWidth-1:0]    x_in,
    output logic                    x_ready,
    output logic                    mem_ren,
    output logic [addressWidth-1:0] mem_radd,
    input  logic [dataWidth-1:0]    mem_wout,
    output logic                    pair_valid,
    output logic [dataWidth-1:0]    pair_w,
    output logic [dataWidth-1:0]    pair_x,
    output logic                    pair_last,
    output logic                    busy,
    output logic                    done
);

    // One spare bit so the count can reach numWeight without wrapping.
    localparam int                 cntWidth = addressWidth + 1;
    localparam logic [cntWidth-1:0] lastIdx = cntWidth'(numWeight - 1);

    seq_state_t            state, state_nx;
    logic [cntWidth-1:0]   cnt, cnt_nx;
    logic                  accept;
    logic                  vld_q;
    logic                  last_q;
    logic [dataWidth-1:0]  x_q;

    assign x_ready  = (state == RUN);
    assign accept   = x_ready && x_valid;
    assign mem_ren  = accept;
    assign mem_radd = cnt[addressWidth-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            x_q    <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            vld_q  <= accept;
            last_q <= accept && (cnt == lastIdx);
            if (accept)
                x_q <= x_in;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    cnt_nx   = '0;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    cnt_nx = cnt + cntWidth'(1);
                    if (cnt == lastIdx)
                        state_nx = DRAIN;
                end
            end
            DRAIN:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Memory data lands in the cycle after the read, aligned with vld_q,
    // so the weight is forwarded rather than registered a second time.
    assign pair_valid = vld_q;
    assign pair_w     = vld_q ? mem_wout : '0;
    assign pair_x     = x_q;
    assign pair_last  = last_q;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

endmodule
